// File: rtl/demux4_router.sv
// 1-to-4 demultiplexing router: steers a valid/ready input stream into four
// independent one-entry holding buffers selected by in_sel.
module demux4_router #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] xfer_count
);

    logic       acc;
    logic [3:0] push;
    logic [3:0] pop;

    // Pass-through ready: a channel draining this cycle can refill in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        acc      = 1'b0;
        push     = 4'b0000;
        pop      = out_valid & out_ready;
        if (rst) begin
            in_ready = ~out_valid[in_sel] | out_ready[in_sel];
        end
        acc = in_valid & in_ready;
        if (acc) begin
            push = 4'(4'b0001 << in_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 4'b0000;
            out_data0  <= '0;
            out_data1  <= '0;
            out_data2  <= '0;
            out_data3  <= '0;
            xfer_count <= '0;
        end else begin
            out_valid <= (out_valid & ~pop) | push;
            if (push[0]) out_data0 <= in_data;
            if (push[1]) out_data1 <= in_data;
            if (push[2]) out_data2 <= in_data;
            if (push[3]) out_data3 <= in_data;
            if (acc) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux4_router.sv
// Self-checking bench for demux4_router: directed scenarios plus randomized
// traffic compared against a per-channel occupancy/data model.
module tb_demux4_router;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [CNT_W-1:0] xfer_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: occupancy flag and held word per channel, transfer count.
    bit               mv[4];
    logic [WIDTH-1:0] md[4];
    int               mcnt;

    demux4_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] dut_data(input int i);
        case (i)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    function automatic bit model_ready();
        return (rst === 1'b1) && (!mv[in_sel] || out_ready[in_sel] === 1'b1);
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mv[i];
        return v;
    endfunction

    task automatic drive(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic step();
        bit acc;
        acc = in_valid && model_ready();
        if (rst !== 1'b1) begin
            for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; md[i] = '0; end
            mcnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) if (mv[i] && out_ready[i]) mv[i] = 1'b0;
            if (acc) begin
                mv[in_sel] = 1'b1;
                md[in_sel] = in_data;
                mcnt = (mcnt + 1) % (1 << CNT_W);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 2'd1, 32'hDEAD_BEEF, 4'b1111);
        step();
        step();
        checks++;
        if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_data(i) !== '0) begin failures++; $display("FAIL reset_data%0d got=%h exp=0", i, dut_data(i)); end
        end
        checks++;
        if (xfer_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", xfer_count); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_routing();
        logic [WIDTH-1:0] words[4];
        words = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), words[k], 4'b1111);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL route_ready%0d got=%b exp=1", k, in_ready); end
            step();
            checks++;
            if (out_valid !== 4'(1 << k)) begin failures++; $display("FAIL route_valid%0d got=%b exp=%b", k, out_valid, 4'(1 << k)); end
            checks++;
            if (dut_data(k) !== words[k]) begin failures++; $display("FAIL route_data%0d got=%h exp=%h", k, dut_data(k), words[k]); end
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();
        checks++;
        if (xfer_count !== 16'd4) begin failures++; $display("FAIL route_count got=%0d exp=4", xfer_count); end
        checks++;
        if (out_valid !== 4'b0000) begin failures++; $display("FAIL route_drained got=%b exp=0000", out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'd2, 32'h11, 4'b1011);
        step();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 32'h11) begin
            failures++; $display("FAIL bp_first got=%b/%h exp=1/00000011", out_valid[2], out_data2);
        end
        drive(1'b1, 2'd2, 32'h22, 4'b1011);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_blocked_ready got=%b exp=0", in_ready); end
        step();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 32'h11) begin
            failures++; $display("FAIL bp_hold got=%b/%h exp=1/00000011", out_valid[2], out_data2);
        end
        drive(1'b1, 2'd2, 32'h22, 4'b1111);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_passthru_ready got=%b exp=1", in_ready); end
        step();
        checks++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 32'h22) begin
            failures++; $display("FAIL bp_refill got=%b/%h exp=1/00000022", out_valid[2], out_data2);
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();
    endtask

    task automatic test_independence();
        drive(1'b1, 2'd1, 32'h44, 4'b0000);
        step();
        drive(1'b1, 2'd3, 32'h55, 4'b0000);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL indep_ready got=%b exp=1", in_ready); end
        step();
        checks++;
        if (out_valid !== 4'b1010) begin failures++; $display("FAIL indep_valid got=%b exp=1010", out_valid); end
        checks++;
        if (out_data3 !== 32'h55) begin failures++; $display("FAIL indep_data3 got=%h exp=00000055", out_data3); end
        checks++;
        if (out_data1 !== 32'h44) begin failures++; $display("FAIL indep_data1 got=%h exp=00000044", out_data1); end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();
    endtask

    task automatic test_pop_push();
        drive(1'b1, 2'd0, 32'h01, 4'b0000);
        step();
        drive(1'b1, 2'd0, 32'h02, 4'b0001);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL popush_ready got=%b exp=1", in_ready); end
        step();
        checks++;
        if (out_valid[0] !== 1'b1 || out_data0 !== 32'h02) begin
            failures++; $display("FAIL popush_data got=%b/%h exp=1/00000002", out_valid[0], out_data0);
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), $urandom, 4'b0000);
            step();
        end
        checks++;
        if (out_valid !== 4'b1111) begin failures++; $display("FAIL mid_fill got=%b exp=1111", out_valid); end
        rst = 1'b0;
        drive(1'b1, 2'd0, 32'h77, 4'b0000);
        step();
        rst = 1'b1;
        checks++;
        if (out_valid !== 4'b0000) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0000", out_valid); end
        checks++;
        if (xfer_count !== '0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", xfer_count); end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 65535; n++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), $urandom, 4'b1111);
            step();
        end
        checks++;
        if (xfer_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%0d exp=65535", xfer_count); end
        drive(1'b1, 2'd1, 32'h99, 4'b1111);
        step();
        checks++;
        if (xfer_count !== 16'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", xfer_count); end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)));
            checks++;
            if (in_ready !== model_ready()) begin
                failures++; $display("FAIL rand_ready it=%0d got=%b exp=%b", n, in_ready, model_ready());
            end
            step();
            checks++;
            if (out_valid !== model_valid()) begin
                failures++; $display("FAIL rand_valid it=%0d got=%b exp=%b", n, out_valid, model_valid());
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dut_data(i) !== md[i]) begin
                    failures++; $display("FAIL rand_data%0d it=%0d got=%h exp=%h", i, n, dut_data(i), md[i]);
                end
            end
            checks++;
            if (xfer_count !== CNT_W'(mcnt)) begin
                failures++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", n, xfer_count, mcnt);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; md[i] = '0; end
        mcnt = 0;
        #2;
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_pop_push();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
